benes_switch_sequencer: RTL and testbench



---
 rtl/USER_PARAM_PKG.sv | 19 +
 rtl/ctx_delay_line.sv | 68 ++++++
 rtl/benes_switch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_benes_switch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/USER_PARAM_PKG.sv
// Shared interconnect parameters: Benes network geometry plus the
// switch-sequencer defaults and types used by the control side.
package USER_PARAM_PKG;

  localparam int SIZE       = 8;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;

  localparam int SEQ_CTX_NUM   = 4;
  localparam int SEQ_STAGE_LAT = 2;

  typedef logic [SWITCH_NUM-1:0] switch_row_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ctx_delay_line.sv
// Context-id delay line for one network stage. Carries {valid, id} through
// DEPTH registers so a stage sees the context its beat was launched with.
// DEPTH = 0 degenerates to a wire. query_hit reports whether any valid entry
// still held inside the line matches query_id (used to hold off rewrites).
module ctx_delay_line #(
  parameter int DEPTH = 0,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  input  logic [ID_W-1:0] query_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id,
  output logic            query_hit
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, query_id};
    assign out_vld   = in_vld;
    assign out_id    = in_id;
    assign query_hit = 1'b0;
  end else begin : g_regs
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [ID_W-1:0]  id_q [DEPTH];
    logic [ID_W-1:0]  id_d [DEPTH];

    // Shift the line by one slot per clock, new entry enters slot 0.
    always_comb begin
      vld_d    = '0;
      id_d     = '{default: '0};
      vld_d[0] = in_vld;
      id_d[0]  = in_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
    end

    // Valid bits are control state: cleared by reset so the line empties.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end

    // Context ids are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
      id_q <= id_d;
    end

    // Flag any valid in-flight entry that belongs to the queried context.
    always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (id_q[i] == query_id)) query_hit = 1'b1;
      end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_id  = id_q[DEPTH-1];
  end

endmodule

// File: rtl/benes_switch_sequencer.sv
// Benes switch sequencer: stores pre-routed switch contexts written over the
// config stream and replays them onto the per-stage switch_set bus, skewing
// each stage by its pipeline depth so every beat sees the context it was
// launched with. beat_valid is the launch strobe for the data source.
module benes_switch_sequencer
  import USER_PARAM_PKG::*;
#(
  parameter int CTX_NUM   = SEQ_CTX_NUM,
  parameter int STAGE_LAT = SEQ_STAGE_LAT,
  parameter int LEN_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [$clog2(CTX_NUM)-1:0]           cfg_ctx,
  input  logic [$clog2(STAGE_NUM)-1:0]         cfg_stage,
  input  logic [SWITCH_NUM-1:0]                cfg_bits,
  input  logic                                 cfg_last,
  input  logic                                 run_valid,
  output logic                                 run_ready,
  input  logic [$clog2(CTX_NUM)-1:0]           run_ctx,
  input  logic [LEN_W-1:0]                     run_len,
  output logic                                 beat_valid,
  output logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] switch_set,
  output logic                                 err_ctx
);

  localparam int CTX_W = $clog2(CTX_NUM);
  localparam int STG_W = $clog2(STAGE_NUM);
  localparam logic [STG_W-1:0] STAGE_MAX = STG_W'(STAGE_NUM - 1);

  // Context storage (rows are data, ctx_ok is control)
  switch_row_t        rows_q [CTX_NUM][STAGE_NUM];
  switch_row_t        rows_d [CTX_NUM][STAGE_NUM];
  logic [CTX_NUM-1:0] ctx_ok_q, ctx_ok_d;

  // Run FSM and beat source
  seq_state_e         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [CTX_W-1:0]   cur_ctx_q, cur_ctx_d;
  logic               cur_ok_q, cur_ok_d;
  logic               err_ctx_q, err_ctx_d;
  logic               cfg_en_q, cfg_en_d;

  logic               cfg_fire;
  logic               cfg_block;
  logic               line_vld_in;

  // Per-stage skew line taps
  logic [STAGE_NUM-1:0] tap_vld;
  logic [STAGE_NUM-1:0] tap_hit;
  logic [CTX_W-1:0]     tap_id [STAGE_NUM];

  assign cfg_fire    = cfg_valid && cfg_ready;
  assign line_vld_in = beat_valid && cur_ok_q;
  assign err_ctx     = err_ctx_q;
  assign cfg_en_d    = 1'b1;

  // Row write and context-valid update; a non-last beat invalidates the context.
  always_comb begin
    rows_d   = rows_q;
    ctx_ok_d = ctx_ok_q;
    if (cfg_fire) begin
      if (cfg_stage <= STAGE_MAX) rows_d[cfg_ctx][cfg_stage] = cfg_bits;
      ctx_ok_d[cfg_ctx] = cfg_last;
    end
  end

  // Row contents are qualified by ctx_ok, so they are left unreset.
  always_ff @(posedge clk) begin
    rows_q <= rows_d;
  end

  // Run FSM: next state, counter reload/decrement, handshake and beat strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_ctx_d  = cur_ctx_q;
    cur_ok_d   = cur_ok_q;
    err_ctx_d  = err_ctx_q;
    run_ready  = 1'b0;
    beat_valid = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        run_ready = 1'b1;
      end
      SEQ_RUN: begin
        beat_valid = 1'b1;
        run_ready  = (cnt_q == '0);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    // Acceptance overrides the fall-back to IDLE, giving bubble-free reloads.
    // The run samples ctx_ok before any same-cycle config write lands.
    if (run_valid && run_ready) begin
      state_d   = SEQ_RUN;
      cnt_d     = run_len;
      cur_ctx_d = run_ctx;
      cur_ok_d  = ctx_ok_q[run_ctx];
      if (!ctx_ok_q[run_ctx]) err_ctx_d = 1'b1;
    end
  end

  // Control state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      cnt_q     <= '0;
      cur_ctx_q <= '0;
      cur_ok_q  <= 1'b0;
      err_ctx_q <= 1'b0;
      ctx_ok_q  <= '0;
      cfg_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_ctx_q <= cur_ctx_d;
      cur_ok_q  <= cur_ok_d;
      err_ctx_q <= err_ctx_d;
      ctx_ok_q  <= ctx_ok_d;
      cfg_en_q  <= cfg_en_d;
    end
  end

  // One skew line per stage, depth s*STAGE_LAT, all fed from the beat source.
  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    ctx_delay_line #(
      .DEPTH (s * STAGE_LAT),
      .ID_W  (CTX_W)
    ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (line_vld_in),
      .in_id     (cur_ctx_q),
      .query_id  (cfg_ctx),
      .out_vld   (tap_vld[s]),
      .out_id    (tap_id[s]),
      .query_hit (tap_hit[s])
    );
  end

  // Hold off config to the running context or any context still in flight.
  always_comb begin
    cfg_block = (state_q == SEQ_RUN) && (cur_ctx_q == cfg_ctx);
    for (int s = 0; s < STAGE_NUM; s++) begin
      if (tap_hit[s]) cfg_block = 1'b1;
    end
    cfg_ready = cfg_en_q && !cfg_block;
  end

  // Drive each stage column from its delayed context, zeros when not valid.
  always_comb begin
    switch_set = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      if (tap_vld[s]) begin
        for (int w = 0; w < SWITCH_NUM; w++) begin
          switch_set[w][s] = rows_q[tap_id[s]][s][w];
        end
      end
    end
  end

endmodule

// File: tb/tb_benes_switch_sequencer.sv
// Scoreboard bench for benes_switch_sequencer: stimulus pushes the expected
// per-beat context rows; a negedge monitor pops them on beat_valid and checks
// every stage column against the skewed history.
module tb_benes_switch_sequencer;
  import USER_PARAM_PKG::*;

  localparam int CTX_NUM   = 4;
  localparam int STAGE_LAT = 2;
  localparam int LEN_W     = 16;
  localparam int CW        = $clog2(CTX_NUM);
  localparam int SW        = $clog2(STAGE_NUM);
  localparam int HIST      = (STAGE_NUM - 1) * STAGE_LAT + 1;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] rows_t;

  logic                                 clk = 1'b0;
  logic                                 rst_n;
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [CW-1:0]                        cfg_ctx;
  logic [SW-1:0]                        cfg_stage;
  logic [SWITCH_NUM-1:0]                cfg_bits;
  logic                                 cfg_last;
  logic                                 run_valid;
  logic                                 run_ready;
  logic [CW-1:0]                        run_ctx;
  logic [LEN_W-1:0]                     run_len;
  logic                                 beat_valid;
  logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] switch_set;
  logic                                 err_ctx;

  int checks   = 0;
  int failures = 0;

  rows_t       exp_q [$];
  rows_t       hist [HIST];
  rows_t       mon_cur;
  logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] mon_ss;
  switch_row_t m_rows [CTX_NUM][STAGE_NUM];
  logic [CTX_NUM-1:0] m_ok;

  benes_switch_sequencer #(
    .CTX_NUM   (CTX_NUM),
    .STAGE_LAT (STAGE_LAT),
    .LEN_W     (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ctx    (cfg_ctx),
    .cfg_stage  (cfg_stage),
    .cfg_bits   (cfg_bits),
    .cfg_last   (cfg_last),
    .run_valid  (run_valid),
    .run_ready  (run_ready),
    .run_ctx    (run_ctx),
    .run_len    (run_len),
    .beat_valid (beat_valid),
    .switch_set (switch_set),
    .err_ctx    (err_ctx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expected beat per launched beat, check every stage column.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST; i++) hist[i] = '0;
    end else begin
      mon_cur = '0;
      if (beat_valid) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) mon_cur = exp_q.pop_front();
      end
      for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = mon_cur;
      mon_ss = '0;
      for (int s = 0; s < STAGE_NUM; s++)
        for (int w = 0; w < SWITCH_NUM; w++)
          mon_ss[w][s] = hist[s * STAGE_LAT][s][w];
      chk("switch_set", 64'(switch_set), 64'(mon_ss));
    end
  end

  task automatic cfg_write(input int ctx, input int stg, input int bits, input logic last);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_ctx   = CW'(ctx);
    cfg_stage = SW'(stg);
    cfg_bits  = SWITCH_NUM'(bits);
    cfg_last  = last;
    #1;
    while (!cfg_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("cfg_accept", 64'(cfg_ready), 64'(1));
    if (cfg_ready) begin
      m_rows[ctx][stg] = SWITCH_NUM'(bits);
      m_ok[ctx]        = last;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic load_ctx(input int ctx, input int base);
    for (int s = 0; s < STAGE_NUM; s++) cfg_write(ctx, s, base + s, 1'(s == STAGE_NUM - 1));
  endtask

  task automatic push_run(input int ctx, input int len);
    rows_t r;
    r = '0;
    if (m_ok[ctx]) for (int s = 0; s < STAGE_NUM; s++) r[s] = m_rows[ctx][s];
    for (int b = 0; b <= len; b++) exp_q.push_back(r);
  endtask

  task automatic run_issue(input int ctx, input int len);
    int n = 0;
    while (!run_ready && n < 100) begin
      @(negedge clk); n++;
    end
    chk("run_ready_wait", 64'(run_ready), 64'(1));
    run_valid = 1'b1;
    run_ctx   = CW'(ctx);
    run_len   = LEN_W'(len);
    push_run(ctx, len);
    @(negedge clk);
    run_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((beat_valid || exp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain_bound", 64'(n < 200), 64'(1));
    repeat (HIST + 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    run_valid = 1'b0;
    exp_q.delete();
    m_ok = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ctx = '0; cfg_stage = '0; cfg_bits = '0;
    cfg_last = 1'b0; run_valid = 1'b0; run_ctx = '0; run_len = '0; m_ok = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_run_ready", 64'(run_ready), 64'(1));
    chk("rst_beat_valid", 64'(beat_valid), 64'(0));
    chk("rst_switch_set", 64'(switch_set), 64'(0));
    chk("rst_err_ctx", 64'(err_ctx), 64'(0));
    chk("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("cfg_ready_at_release", 64'(cfg_ready), 64'(0));
    @(negedge clk); #1;
    chk("cfg_ready_after_release", 64'(cfg_ready), 64'(1));

    // Load ctx 1 with row s = s+1, run it for 4 beats straight after cfg_last
    load_ctx(1, 1);
    run_issue(1, 3);
    drain();
    chk("err_after_valid_run", 64'(err_ctx), 64'(0));

    // Back-to-back runs: ctx 0 (1 beat) then ctx 1 (2 beats), no bubble
    load_ctx(0, 8);
    run_issue(0, 0);
    chk("b2b_beat1", 64'(beat_valid), 64'(1));
    run_issue(1, 1);
    chk("b2b_beat2", 64'(beat_valid), 64'(1));
    @(negedge clk);
    chk("b2b_beat3", 64'(beat_valid), 64'(1));
    @(negedge clk);
    chk("b2b_end", 64'(beat_valid), 64'(0));
    drain();

    // cfg to running ctx 1 held off until the last skew line empties; ctx 3 goes through
    run_issue(1, 10);
    cfg_valid = 1'b1; cfg_ctx = CW'(1); cfg_stage = SW'(1); cfg_bits = 4'h2; cfg_last = 1'b1;
    #1;
    chk("cfg_block_running", 64'(cfg_ready), 64'(0));
    cfg_ctx = CW'(3); cfg_stage = SW'(0); cfg_bits = 4'h5; cfg_last = 1'b1;
    #1;
    chk("cfg_other_ctx_ready", 64'(cfg_ready), 64'(1));
    m_rows[3][0] = 4'h5; m_ok[3] = 1'b1;
    @(negedge clk);
    cfg_ctx = CW'(1); cfg_stage = SW'(1); cfg_bits = 4'h2; cfg_last = 1'b1;
    k = 2;
    #1;
    while (!cfg_ready && k < 40) begin
      @(negedge clk); #1; k++;
    end
    chk("cfg_unblock_cycle", 64'(k), 64'(20));
    m_rows[1][1] = 4'h2; m_ok[1] = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    drain();

    // Run on never-configured ctx 2 with a simultaneous cfg_last to ctx 2
    chk("run_ready_before_err", 64'(run_ready), 64'(1));
    cfg_valid = 1'b1; cfg_ctx = CW'(2); cfg_stage = SW'(0); cfg_bits = 4'hF; cfg_last = 1'b1;
    run_valid = 1'b1; run_ctx = CW'(2); run_len = LEN_W'(2);
    push_run(2, 2);
    #1;
    chk("cfg_ready_same_cycle", 64'(cfg_ready), 64'(1));
    chk("err_before_accept", 64'(err_ctx), 64'(0));
    m_rows[2][0] = 4'hF; m_ok[2] = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; run_valid = 1'b0;
    chk("err_after_accept", 64'(err_ctx), 64'(1));
    drain();

    // Reset at the 5th beat of a 16-beat run
    run_issue(1, 15);
    repeat (4) @(negedge clk);
    chk("pre_reset_beat", 64'(beat_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_beat_valid", 64'(beat_valid), 64'(0));
    chk("mid_reset_switch_set", 64'(switch_set), 64'(0));
    chk("mid_reset_err", 64'(err_ctx), 64'(0));
    chk("mid_reset_run_ready", 64'(run_ready), 64'(1));
    exp_q.delete();
    m_ok = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_issue(1, 0);
    chk("ctx1_invalid_after_reset", 64'(err_ctx), 64'(1));
    drain();

    // Partial rewrite invalidates a valid context
    do_reset();
    chk("err_cleared", 64'(err_ctx), 64'(0));
    load_ctx(0, 8);
    run_issue(0, 0);
    drain();
    chk("ctx0_valid_run", 64'(err_ctx), 64'(0));
    cfg_write(0, 2, 3, 1'b0);
    run_issue(0, 1);
    chk("ctx0_partial_err", 64'(err_ctx), 64'(1));
    drain();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
